wr_ptr_full: RTL and testbench

- Write-domain pointer and status generator for the asynchronous FIFO.
- Holds the binary write counter and produces the Gray-coded write pointer that is sent to the read domain.
- Synchronizes the read domain's Gray pointer into the write clock and generates full, almost_full, fill level and overflow flags.
- Sits directly upstream of the FIFO memory write port and of the write-to-read pointer synchronizer.

---
 rtl/wr_ptr_full.sv | 102 ++++++++++
 tb/tb_wr_ptr_full.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wr_ptr_full.sv
// Write-domain pointer/status block for an asynchronous FIFO: binary/Gray write
// pointer, read-pointer synchronizer, and full/almost_full/level/overflow flags.
`timescale 1ns/1ps
module wr_ptr_full #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_gray,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_gray,
  output logic              wr_accept,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'((2 ** ADDR_W) - AF_MARGIN);

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq, rd_bin, full_cmp, diff;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;

  // Plain flop chain: nothing may sit between stages.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q[gi] <= '0;
        end else begin
          if (gi == 0) sync_q[gi] <= rd_gray;
          else         sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign rq = sync_q[SYNC_STAGES-1];

  // Gray -> binary: each bit is the XOR of all Gray bits at or above it.
  generate
    for (gi = 0; gi < PW; gi++) begin : g_g2b
      assign rd_bin[gi] = ^rq[PW-1:gi];
    end
  endgenerate

  generate
    if (ADDR_W == 1) begin : g_cmp1
      assign full_cmp = {~rq[1], rq[0]};
    end else begin : g_cmpn
      assign full_cmp = {~rq[PW-1:PW-2], rq[PW-3:0]};
    end
  endgenerate

  always_comb begin
    wr_accept = wr_en && !full_q;
    bin_d     = bin_q + PW'(wr_accept);
    gray_d    = bin_d ^ (bin_d >> 1);
    diff      = bin_d - rd_bin;
    full_d    = (gray_d == full_cmp);
    af_d      = (diff >= AF_THRESH);
    level_d   = diff;
    ovf_d     = wr_en && full_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      full_q  <= full_d;
      af_q    <= af_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr     = bin_q[ADDR_W-1:0];
  assign wr_gray     = gray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign level       = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wr_ptr_full.sv
// Bench for wr_ptr_full: fill/overflow vector table, hand-written drain/wrap/
// simultaneous-event sequences, then random traffic against a counting model.
`timescale 1ns/1ps
module tb_wr_ptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] rd_gray;
  logic [3:0] wr_addr;
  logic [4:0] wr_gray;
  logic       wr_accept, full, almost_full, overflow;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;

  wr_ptr_full #(.ADDR_W(4), .SYNC_STAGES(2), .AF_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_gray(rd_gray),
    .wr_addr(wr_addr), .wr_gray(wr_gray), .wr_accept(wr_accept),
    .full(full), .almost_full(almost_full), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [4:0] rg;
    logic       acc;
    logic [3:0] addr;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] g(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  // Inputs change just after the falling edge; outputs are read there too.
  task automatic setin(input logic we, input logic [4:0] rg);
    wr_en   = we;
    rd_gray = rg;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] gl[16];
    int wcnt, rdc, d, rs, rdprob;
    logic we, full_m, ovf_m, acc_m;
    int sq[$];

    gl = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
           5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};
    for (int i = 0; i < 16; i++) begin
      vecs[i].we = 1'b1;  vecs[i].rg = 5'd0;   vecs[i].acc = 1'b1;
      vecs[i].addr = 4'((i + 1) % 16);        vecs[i].gray = gl[i];
      vecs[i].full = (i == 15); vecs[i].af = (i >= 13);
      vecs[i].lvl = 5'(i + 1);  vecs[i].ovf = 1'b0;
    end
    for (int i = 16; i < 19; i++) begin
      vecs[i].we = 1'b1;  vecs[i].rg = 5'd0;   vecs[i].acc = 1'b0;
      vecs[i].addr = 4'd0; vecs[i].gray = 5'b11000;
      vecs[i].full = 1'b1; vecs[i].af = 1'b1;
      vecs[i].lvl = 5'd16; vecs[i].ovf = 1'b1;
    end

    rst = 1'b1; wr_en = 1'b0; rd_gray = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset asserted mid-cycle while writing.
    for (int k = 0; k < 5; k++) begin setin(1'b1, 5'd0); step(); end
    check("pre_rst.addr", 32'(wr_addr), 32'd5);
    @(posedge clk); #2; rst = 1'b1; #1;
    check("rst.addr",  32'(wr_addr),  32'd0);
    check("rst.gray",  32'(wr_gray),  32'd0);
    check("rst.full",  32'(full),     32'd0);
    check("rst.af",    32'(almost_full), 32'd0);
    check("rst.level", 32'(level),    32'd0);
    check("rst.ovf",   32'(overflow), 32'd0);
    @(negedge clk); rst = 1'b0; wr_en = 1'b0; #1;
    check("post_rst.addr", 32'(wr_addr), 32'd0);
    $display("reset mid-cycle sequence done");

    // Fill then overflow, table driven.
    for (int i = 0; i < 19; i++) begin
      setin(vecs[i].we, vecs[i].rg);
      check($sformatf("v%0d.acc", i), 32'(wr_accept), 32'(vecs[i].acc));
      step();
      check($sformatf("v%0d.addr", i),  32'(wr_addr),     32'(vecs[i].addr));
      check($sformatf("v%0d.gray", i),  32'(wr_gray),     32'(vecs[i].gray));
      check($sformatf("v%0d.full", i),  32'(full),        32'(vecs[i].full));
      check($sformatf("v%0d.af", i),    32'(almost_full), 32'(vecs[i].af));
      check($sformatf("v%0d.level", i), 32'(level),       32'(vecs[i].lvl));
      check($sformatf("v%0d.ovf", i),   32'(overflow),    32'(vecs[i].ovf));
      $display("vec %0d: wr_en=%0b addr=%0d gray=%b full=%0b level=%0d ovf=%0b",
               i, vecs[i].we, wr_addr, wr_gray, full, level, overflow);
    end
    setin(1'b0, 5'd0); step();
    check("ovf_end.ovf",   32'(overflow), 32'd0);
    check("ovf_end.level", 32'(level),    32'd16);

    // Drain visibility: exactly SYNC_STAGES+1 cycles.
    setin(1'b0, 5'b00110);
    step(); check("drain.c1.full", 32'(full), 32'd1);
    check("drain.c1.level", 32'(level), 32'd16);
    step(); check("drain.c2.full", 32'(full), 32'd1);
    step(); check("drain.c3.full", 32'(full), 32'd0);
    check("drain.c3.level", 32'(level), 32'd12);
    check("drain.c3.af",    32'(almost_full), 32'd0);
    $display("drain sequence done: full=%0b level=%0d", full, level);

    // Wrap: reader at 16, writer goes 16 -> 31 -> 0.
    setin(1'b0, 5'b11000);
    repeat (3) step();
    check("wrap.pre.level", 32'(level), 32'd0);
    check("wrap.pre.full",  32'(full),  32'd0);
    for (int k = 0; k < 16; k++) begin
      setin(1'b1, 5'b11000);
      check($sformatf("wrap.k%0d.addr", k), 32'(wr_addr), 32'(k));
      check($sformatf("wrap.k%0d.gray", k), 32'(wr_gray), 32'(g(16 + k)));
      step();
    end
    check("wrap.addr",  32'(wr_addr), 32'd0);
    check("wrap.gray",  32'(wr_gray), 32'd0);
    check("wrap.full",  32'(full),    32'd1);
    check("wrap.level", 32'(level),   32'd16);
    $display("wrap sequence done: gray=%b full=%0b level=%0d", wr_gray, full, level);

    // Simultaneous write and synchronized read advance.
    setin(1'b0, g(24));
    repeat (3) step();
    check("sim.pre.level", 32'(level), 32'd8);
    check("sim.pre.full",  32'(full),  32'd0);
    setin(1'b0, g(25));
    step(); step();
    check("sim.mid.level", 32'(level), 32'd8);
    setin(1'b1, g(25));
    check("sim.acc", 32'(wr_accept), 32'd1);
    step();
    check("sim.level", 32'(level),   32'd8);
    check("sim.full",  32'(full),    32'd0);
    check("sim.addr",  32'(wr_addr), 32'd1);
    $display("simultaneous sequence done: level=%0d", level);

    // Random traffic vs counting model (unbounded counts, delayed read view).
    setin(1'b0, 5'd0);
    rst = 1'b1; step(); rst = 1'b0; #1;
    wcnt = 0; rdc = 0; full_m = 1'b0; ovf_m = 1'b0;
    sq = {0, 0};
    for (int c = 0; c < 600; c++) begin
      rdprob = (c < 300) ? 25 : 70;
      we = ($urandom_range(0, 99) < 75);
      if (rdc < wcnt && $urandom_range(0, 99) < rdprob) rdc++;
      setin(we, g(rdc));
      check($sformatf("rnd%0d.acc", c), 32'(wr_accept), 32'(we && !full_m));
      step();
      rs = sq.pop_front();
      sq.push_back(rdc);
      acc_m  = we && !full_m;
      ovf_m  = we && full_m;
      wcnt  += int'(acc_m);
      d      = wcnt - rs;
      full_m = (d == 16);
      check($sformatf("rnd%0d.addr", c),  32'(wr_addr),     32'(wcnt % 16));
      check($sformatf("rnd%0d.gray", c),  32'(wr_gray),     32'(g(wcnt)));
      check($sformatf("rnd%0d.full", c),  32'(full),        32'(full_m));
      check($sformatf("rnd%0d.af", c),    32'(almost_full), 32'(d >= 14));
      check($sformatf("rnd%0d.level", c), 32'(level),       32'(d));
      check($sformatf("rnd%0d.ovf", c),   32'(overflow),    32'(ovf_m));
    end
    $display("random phase done: writes=%0d reads=%0d", wcnt, rdc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
